// File: rtl/fp_pkg.sv
// Shared types and constants for the FP issue/hazard controller.
package fp_pkg;

  localparam int FP_NREG_W = 5;

  localparam logic [1:0] FC_ADD  = 2'b00;
  localparam logic [1:0] FC_MUL  = 2'b01;
  localparam logic [1:0] FC_DIV  = 2'b10;
  localparam logic [1:0] FC_SQRT = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E3 = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HAZ = 2'd1,
    ST_DS  = 2'd2
  } fsm_state_e;

  // Shadow copy of one FPU stage: write flag, destination, op class.
  typedef struct packed {
    logic                 w;
    logic [FP_NREG_W-1:0] n;
    logic [1:0]           c;
  } stage_t;

  function automatic logic stage_hit(input stage_t s, input logic [FP_NREG_W-1:0] r);
    return s.w && (s.n == r);
  endfunction

endpackage

// File: rtl/fp_hazard_cmp.sv
// Compares one source register against the shadow stages; the youngest
// matching stage decides between stall and a forwarding select.
module fp_hazard_cmp
  import fp_pkg::*;
(
  input  logic                 use_i,
  input  logic [FP_NREG_W-1:0] reg_i,
  input  stage_t               e1_i,
  input  stage_t               e2_i,
  input  stage_t               e3_i,
  input  stage_t               w_i,
  output logic                 stall_o,
  output logic [1:0]           fwd_o
);

  logic hit_e1, hit_e2, hit_e3, hit_w;

  assign hit_e1 = use_i & stage_hit(e1_i, reg_i);
  assign hit_e2 = use_i & stage_hit(e2_i, reg_i);
  assign hit_e3 = use_i & stage_hit(e3_i, reg_i);
  assign hit_w  = use_i & stage_hit(w_i, reg_i);

  // E1/E2 results do not exist yet, so they override any older copy.
  assign stall_o = hit_e1 | hit_e2;

  always_comb begin
    fwd_o = FWD_RF;
    if (!stall_o) begin
      if (hit_e3)     fwd_o = FWD_E3;
      else if (hit_w) fwd_o = FWD_W;
    end
  end

  logic unused_cls;
  assign unused_cls = ^{e1_i.c, e2_i.c, e3_i.c, w_i.c};

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue/hazard controller: shadow E1/E2/E3/W pipe, RAW stall, forwarding
// and div/sqrt freeze tracking. Define FP_STALL_CNT_EN for the stall counter.
//   state | meaning
//   RUN   | normal issue
//   HAZ   | stalled on a RAW hazard in E1/E2
//   DS    | pipe frozen by divide/sqrt
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int NREG_W     = FP_NREG_W,
  parameter int STALLCNT_W = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [NREG_W-1:0] id_fs,
  input  logic [NREG_W-1:0] id_ft,
  input  logic [NREG_W-1:0] id_fd,
  input  logic [2:0]        id_fc,
  input  logic              id_wf,
  input  logic              id_use_fs,
  input  logic              id_use_ft,
  input  logic              ein1,
  input  logic              cancel,
  input  logic              st_ds,
  output logic [NREG_W-1:0] iss_fd,
  output logic [2:0]        iss_fc,
  output logic              iss_wf,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_id,
  output logic              e,
  output logic [1:0]        state
`ifdef FP_STALL_CNT_EN
  ,
  output logic [STALLCNT_W-1:0] stall_cnt
`endif
);

  stage_t e1_q, e2_q, e3_q, w_q;
  stage_t e1_d, e2_d, e3_d, w_d;
  fsm_state_e state_q, state_d;
  logic stall_a, stall_b, raw_stall;

  fp_hazard_cmp u_cmp_fs (
    .use_i   (id_use_fs),
    .reg_i   (id_fs),
    .e1_i    (e1_q),
    .e2_i    (e2_q),
    .e3_i    (e3_q),
    .w_i     (w_q),
    .stall_o (stall_a),
    .fwd_o   (fwd_a)
  );

  fp_hazard_cmp u_cmp_ft (
    .use_i   (id_use_ft),
    .reg_i   (id_ft),
    .e1_i    (e1_q),
    .e2_i    (e2_q),
    .e3_i    (e3_q),
    .w_i     (w_q),
    .stall_o (stall_b),
    .fwd_o   (fwd_b)
  );

  assign raw_stall = stall_a | stall_b;
  assign e         = ein1 & ~st_ds;
  assign stall_id  = raw_stall | st_ds | ~ein1;
  assign iss_wf    = id_wf & ~raw_stall & ~cancel;
  assign iss_fd    = id_fd;
  assign iss_fc    = id_fc;
  assign state     = state_q;

  // A stalled or cancelled slot enters E1 as a bubble through iss_wf.
  always_comb begin
    e1_d = e1_q;
    e2_d = e2_q;
    e3_d = e3_q;
    w_d  = w_q;
    if (e) begin
      e1_d = '{w: iss_wf, n: iss_fd, c: iss_fc[2:1]};
      e2_d = e1_q;
      e3_d = e2_q;
      w_d  = e3_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      e1_q <= '0;
      e2_q <= '0;
      e3_q <= '0;
      w_q  <= '0;
    end else begin
      e1_q <= e1_d;
      e2_q <= e2_d;
      e3_q <= e3_d;
      w_q  <= w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (st_ds)          state_d = ST_DS;
        else if (raw_stall) state_d = ST_HAZ;
      end
      ST_HAZ: begin
        if (st_ds)           state_d = ST_DS;
        else if (!raw_stall) state_d = ST_RUN;
      end
      ST_DS: begin
        if (!st_ds) state_d = raw_stall ? ST_HAZ : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

`ifdef FP_STALL_CNT_EN
  logic [STALLCNT_W-1:0] cnt_q, cnt_d;

  // Only stalls raised by the FPU side count; cache stalls are excluded.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_id && ein1 && (cnt_q != '1)) cnt_d = cnt_q + STALLCNT_W'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  logic [STALLCNT_W-1:0] unused_stall_cnt;
  assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed scenarios plus random issue traffic, checked against an
// array model of the four shadow stages.
module tb_fp_issue_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_fs, id_ft, id_fd;
  logic [2:0] id_fc;
  logic       id_wf, id_use_fs, id_use_ft, ein1, cancel, st_ds;
  logic [4:0] iss_fd;
  logic [2:0] iss_fc;
  logic       iss_wf, stall_id, e;
  logic [1:0] fwd_a, fwd_b, state;
`ifdef FP_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int mw[4];
  int mn[4];
  int mst  = 0;
  int mcnt = 0;

  always #5 clk = ~clk;

  fp_issue_ctrl dut (
    .clk       (clk),
    .clrn      (clrn),
    .id_fs     (id_fs),
    .id_ft     (id_ft),
    .id_fd     (id_fd),
    .id_fc     (id_fc),
    .id_wf     (id_wf),
    .id_use_fs (id_use_fs),
    .id_use_ft (id_use_ft),
    .ein1      (ein1),
    .cancel    (cancel),
    .st_ds     (st_ds),
    .iss_fd    (iss_fd),
    .iss_fc    (iss_fc),
    .iss_wf    (iss_wf),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .stall_id  (stall_id),
    .e         (e),
    .state     (state)
`ifdef FP_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0;
      mn[i] = 0;
    end
    mst  = 0;
    mcnt = 0;
  endtask

  // Stage 0 is E1 (youngest); the first hit decides.
  function automatic void src_eval(input logic use_x, input logic [4:0] r,
                                   output logic st, output logic [1:0] fw);
    st = 1'b0;
    fw = 2'b00;
    if (use_x) begin
      for (int i = 0; i < 4; i++) begin
        if (mw[i] != 0 && mn[i] == int'(r)) begin
          if (i < 2) st = 1'b1;
          else       fw = (i == 2) ? 2'b01 : 2'b10;
          break;
        end
      end
    end
  endfunction

  task automatic setid(input int fs, input int ft, input int fd, input int fc,
                       input int wf, input int ufs, input int uft);
    id_fs     = 5'(fs);
    id_ft     = 5'(ft);
    id_fd     = 5'(fd);
    id_fc     = 3'(fc);
    id_wf     = 1'(wf);
    id_use_fs = 1'(ufs);
    id_use_ft = 1'(uft);
  endtask

  task automatic cyc();
    logic sa, sb, raw, ee, exp_wf, exp_stall;
    logic [1:0] fa, fb;
    @(negedge clk);
    src_eval(id_use_fs, id_fs, sa, fa);
    src_eval(id_use_ft, id_ft, sb, fb);
    raw       = sa | sb;
    ee        = ein1 & ~st_ds;
    exp_wf    = id_wf & ~raw & ~cancel;
    exp_stall = raw | st_ds | ~ein1;
    check("stall_id", 16'(stall_id), 16'(exp_stall));
    check("fwd_a", 16'(fwd_a), 16'(fa));
    check("fwd_b", 16'(fwd_b), 16'(fb));
    check("e", 16'(e), 16'(ee));
    check("iss_wf", 16'(iss_wf), 16'(exp_wf));
    check("iss_fd", 16'(iss_fd), 16'(id_fd));
    check("iss_fc", 16'(iss_fc), 16'(id_fc));
    check("state", 16'(state), 16'(mst));
`ifdef FP_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 16'(mcnt));
`endif
    @(posedge clk);
    if (ee) begin
      for (int i = 3; i > 0; i--) begin
        mw[i] = mw[i-1];
        mn[i] = mn[i-1];
      end
      mw[0] = int'(exp_wf);
      mn[0] = int'(id_fd);
    end
    mst = st_ds ? 2 : (raw ? 1 : 0);
    if (ein1 && (raw || st_ds) && mcnt < 65535) mcnt++;
    #1;
  endtask

  initial begin
    clrn   = 1'b0;
    ein1   = 1'b1;
    cancel = 1'b0;
    st_ds  = 1'b0;
    setid(0, 0, 0, 0, 0, 0, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 16'(state), 16'd0);
    check("rst_stall", 16'(stall_id), 16'd0);
    check("rst_fwd_a", 16'(fwd_a), 16'd0);
    check("rst_fwd_b", 16'(fwd_b), 16'd0);
    check("rst_iss_wf", 16'(iss_wf), 16'd0);
`ifdef FP_STALL_CNT_EN
    check("rst_cnt", stall_cnt, 16'd0);
`endif
    clrn = 1'b1;

    // add f3=f1+f2, then dependent mul f5=f3*f4
    setid(1, 2, 3, 3'b000, 1, 1, 1);
    cyc();
    setid(3, 4, 5, 3'b010, 1, 1, 1);
    #1;
    check("s1_stall_e1", 16'(stall_id), 16'd1);
    cyc();
    check("s1_stall_e2", 16'(stall_id), 16'd1);
    check("s1_state_haz", 16'(state), 16'd1);
    cyc();
    check("s1_nostall", 16'(stall_id), 16'd0);
    check("s1_fwd_e3", 16'(fwd_a), 16'd1);
    check("s1_iss_wf", 16'(iss_wf), 16'd1);
    cyc();

    // add f3, three independent ops, then sub f6=f7-f3 reads W
    setid(1, 2, 3, 3'b000, 1, 1, 1);
    cyc();
    setid(10, 11, 12, 3'b010, 1, 1, 1);
    cyc();
    setid(13, 14, 15, 3'b000, 1, 1, 1);
    cyc();
    setid(17, 18, 16, 3'b000, 1, 1, 1);
    cyc();
    setid(7, 3, 6, 3'b001, 1, 1, 1);
    #1;
    check("s2_nostall", 16'(stall_id), 16'd0);
    check("s2_fwd_w", 16'(fwd_b), 16'd2);
    cyc();

    // add f21, fdiv f8, independent op, then reader of f21 during a 10-cycle freeze
    setid(1, 2, 21, 3'b000, 1, 1, 1);
    cyc();
    setid(1, 2, 8, 3'b100, 1, 1, 1);
    cyc();
    setid(1, 2, 22, 3'b010, 1, 1, 1);
    cyc();
    setid(21, 9, 23, 3'b000, 1, 1, 1);
    st_ds = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cancel = (k == 4);
      cyc();
    end
    cancel = 1'b0;
    #1;
    check("s3_state_ds", 16'(state), 16'd2);
    check("s3_e_frozen", 16'(e), 16'd0);
    check("s3_fwd_hold", 16'(fwd_a), 16'd1);
    st_ds = 1'b0;
    cyc();
    check("s3_state_run", 16'(state), 16'd0);

    // cancelled add f3 leaves a bubble; reader of f3 sees no hazard
    setid(1, 2, 3, 3'b000, 1, 1, 1);
    cancel = 1'b1;
    cyc();
    cancel = 1'b0;
    setid(3, 4, 24, 3'b010, 1, 1, 1);
    #1;
    check("s4_nostall", 16'(stall_id), 16'd0);
    check("s4_fwd_rf", 16'(fwd_a), 16'd0);
    cyc();

    // f9 in E1 and in E3: E1 copy wins until it reaches E3
    setid(1, 2, 9, 3'b000, 1, 1, 1);
    cyc();
    setid(1, 2, 25, 3'b000, 1, 1, 1);
    cyc();
    setid(1, 2, 9, 3'b010, 1, 1, 1);
    cyc();
    setid(9, 4, 26, 3'b000, 1, 1, 0);
    #1;
    check("s5_stall_e1", 16'(stall_id), 16'd1);
    cyc();
    check("s5_stall_e2", 16'(stall_id), 16'd1);
    cyc();
    check("s5_nostall", 16'(stall_id), 16'd0);
    check("s5_fwd_e3", 16'(fwd_a), 16'd1);
    cyc();

    // asynchronous reset while in HAZ
    setid(1, 2, 3, 3'b000, 1, 1, 1);
    cyc();
    setid(3, 4, 27, 3'b010, 1, 1, 1);
    cyc();
    check("s6_pre_haz", 16'(state), 16'd1);
    clrn = 1'b0;
    #1;
    check("s6_rst_state", 16'(state), 16'd0);
    check("s6_rst_stall", 16'(stall_id), 16'd0);
    check("s6_rst_fwd_a", 16'(fwd_a), 16'd0);
    check("s6_rst_iss_wf", 16'(iss_wf), 16'(id_wf & ~cancel));
`ifdef FP_STALL_CNT_EN
    check("s6_rst_cnt", stall_cnt, 16'd0);
`endif
    mreset();
    @(posedge clk);
    #1;
    clrn = 1'b1;
    cyc();

    // random traffic over a small register window to provoke hazards
    for (int k = 0; k < 400; k++) begin
      setid($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1));
      ein1   = ($urandom_range(0, 7) != 0);
      st_ds  = ($urandom_range(0, 9) == 0);
      cancel = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
